// File: rtl/sva_abort_window_monitor_if.sv
// rtl/sva_abort_window_monitor_if.sv - stimulus/verdict bundle for the abort-window monitor
interface sva_abort_window_monitor_if #(
    parameter int NCH = 4,
    parameter int FCW = 8
);
    logic           dis;
    logic [NCH-1:0] req;
    logic [NCH-1:0] ack;
    logic [NCH-1:0] abort;
    logic [NCH-1:0] abort_rej;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] pass;
    logic [NCH-1:0] fail;
    logic [NCH-1:0] aborted;
    logic [FCW-1:0] fail_cnt;

    modport master (
        output dis, req, ack, abort, abort_rej,
        input  busy, pass, fail, aborted, fail_cnt
    );

    modport slave (
        input  dis, req, ack, abort, abort_rej,
        output busy, pass, fail, aborted, fail_cnt
    );
endinterface

// File: rtl/sva_abort_window_monitor.sv
// rtl/sva_abort_window_monitor.sv - per-channel req ##[MIN:MAX] ack checker with accept/reject abort
module sva_abort_window_monitor #(
    parameter int NCH        = 4,
    parameter int MIN_DLY    = 1,
    parameter int MAX_DLY    = 10,
    parameter int SYNC_ABORT = 0,
    parameter int FCW        = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    sva_abort_window_monitor_if.slave  mon
);
    localparam int CW = $clog2(MAX_DLY + 1);
    localparam int SW = ((FCW > 6) ? FCW : 6) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e         state_q [NCH];
    state_e         state_d [NCH];
    logic [CW-1:0]  cnt_q   [NCH];
    logic [CW-1:0]  cnt_d   [NCH];

    logic [NCH-1:0] pass_q, pass_d;
    logic [NCH-1:0] fail_q, fail_d;
    logic [NCH-1:0] aborted_q, aborted_d;
    logic [NCH-1:0] abort_q;
    logic [NCH-1:0] abort_eff;
    logic [NCH-1:0] term;
    logic [NCH-1:0] busy_w;
    logic [FCW-1:0] fail_cnt_q, fail_cnt_d;
    logic [5:0]     fail_pop;
    logic [SW-1:0]  fail_sum;

    // sync_* forms see the abort one cycle late; dis also flushes the pipeline
    assign abort_eff = (SYNC_ABORT != 0) ? abort_q : mon.abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            pass_q     <= '0;
            fail_q     <= '0;
            aborted_q  <= '0;
            abort_q    <= '0;
            fail_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            aborted_q  <= aborted_d;
            abort_q    <= mon.dis ? '0 : mon.abort;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    always_comb begin
        pass_d    = '0;
        fail_d    = '0;
        aborted_d = '0;
        term      = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (mon.req[i] && !mon.dis) begin
                        if (abort_eff[i]) begin
                            pass_d[i]    = !mon.abort_rej[i];
                            fail_d[i]    = mon.abort_rej[i];
                            aborted_d[i] = 1'b1;
                        end else begin
                            state_d[i] = WAIT;
                            cnt_d[i]   = CW'(1);
                        end
                    end
                end
                WAIT: begin
                    if (mon.dis) begin
                        state_d[i] = IDLE;
                    end else begin
                        if (abort_eff[i]) begin
                            pass_d[i]    = !mon.abort_rej[i];
                            fail_d[i]    = mon.abort_rej[i];
                            aborted_d[i] = 1'b1;
                            term[i]      = 1'b1;
                        end else if (mon.ack[i] && (cnt_q[i] >= CW'(MIN_DLY))) begin
                            pass_d[i] = 1'b1;
                            term[i]   = 1'b1;
                        end else if (cnt_q[i] == CW'(MAX_DLY)) begin
                            fail_d[i] = 1'b1;
                            term[i]   = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                        // a req in the deciding cycle chains straight into a new attempt
                        if (term[i]) begin
                            if (mon.req[i]) begin
                                state_d[i] = WAIT;
                                cnt_d[i]   = CW'(1);
                            end else begin
                                state_d[i] = IDLE;
                            end
                        end
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // counting the next-state fail vector keeps fail_cnt in step with the fail pulse
    always_comb begin
        fail_pop = '0;
        for (int i = 0; i < NCH; i++) begin
            fail_pop = fail_pop + {5'b0, fail_d[i]};
        end
        fail_sum   = SW'(fail_cnt_q) + SW'(fail_pop);
        fail_cnt_d = (fail_sum > SW'({FCW{1'b1}})) ? {FCW{1'b1}} : fail_sum[FCW-1:0];
    end

    always_comb begin
        busy_w = '0;
        for (int i = 0; i < NCH; i++) begin
            busy_w[i] = (state_q[i] == WAIT);
        end
    end

    assign mon.busy     = busy_w;
    assign mon.pass     = pass_q;
    assign mon.fail     = fail_q;
    assign mon.aborted  = aborted_q;
    assign mon.fail_cnt = fail_cnt_q;
endmodule

// File: doc/sva_abort_window_monitor.md
Name: sva_abort_window_monitor

Overview:
- Synthesizable multi-channel monitor implementing the hardware equivalent of `accept_on` / `reject_on` / `sync_accept_on` / `sync_reject_on` wrapped around a `req ##[MIN_DLY:MAX_DLY] ack` obligation.
- Generalises single-property abort checks to NCH independent channels, with per-channel abort polarity, a configurable delay window, selectable async/sync abort timing, and a global disable.
- Instantiated alongside DUTs in formal and simulation benches, and as an on-chip protocol watchdog.

Parameters:
- NCH, 4, number of independent channels (1..32)
- MIN_DLY, 1, minimum req-to-ack delay in cycles (>=1)
- MAX_DLY, 10, maximum req-to-ack delay in cycles (>=MIN_DLY, <=255)
- SYNC_ABORT, 0, 0 = abort acts in the cycle it is sampled (accept_on/reject_on); 1 = abort registered, acts one cycle later (sync_* forms)
- FCW, 8, width of saturating fail counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- dis  in  1  disable-iff: drops all attempts silently
- req  in  NCH  per-channel attempt start
- ack  in  NCH  per-channel completion
- abort  in  NCH  per-channel abort condition
- abort_rej  in  NCH  per-channel abort kind: 0 = accept (abort passes), 1 = reject (abort fails)
- busy  out  NCH  channel has an attempt in flight
- pass  out  NCH  one-cycle verdict pulse: property held
- fail  out  NCH  one-cycle verdict pulse: property violated
- aborted  out  NCH  one-cycle pulse, coincident with pass/fail, when the verdict came from abort
- fail_cnt  out  FCW  saturating count of all fail pulses

Behaviour:
- Reset: all channels IDLE, cnt=0, abort pipeline cleared. busy, pass, fail, aborted and fail_cnt all 0. Applies mid-attempt with no verdict emitted.
- Per-channel FSM states:
  - IDLE: on req && !dis, go to WAIT with cnt=1. The req cycle is delay 0.
  - WAIT: each cycle, evaluate in priority order dis > abort > ack > timeout:
    - dis: go to IDLE, no verdict pulse.
    - abort_eff: go to IDLE; pass (abort_rej=0) or fail (abort_rej=1), plus aborted.
    - ack && cnt>=MIN_DLY: go to IDLE, pass.
    - ack && cnt<MIN_DLY: ignored; cnt increments.
    - cnt==MAX_DLY with no ack: go to IDLE, fail.
    - otherwise cnt++.
- Verdict pulses are registered: they appear in the cycle after the deciding cycle.
- abort_eff:
  - SYNC_ABORT=0: abort sampled in the current cycle.
  - SYNC_ABORT=1: abort sampled in the previous cycle (1-cycle flop, cleared by rst and by dis).
- Abort at attempt start: in IDLE, if req and abort_eff coincide (and !dis), the attempt starts and is aborted in the same cycle; the verdict appears next cycle. abort_eff in IDLE without req is ignored.
- Back-to-back: req in a WAIT cycle that ends in a verdict starts a new attempt (next state WAIT, cnt=1). req in a non-terminating WAIT cycle is ignored (no overlap).
- busy: high in every cycle the channel is in WAIT.
- fail_cnt: each cycle adds popcount(fail) and saturates at 2^FCW-1. It never wraps.
- Channels are fully independent except for the shared dis and fail_cnt.
- Counter width: ceil(log2(MAX_DLY+1)).

Test Plan:
- MIN_DLY=1, MAX_DLY=10: req@0, ack@3 -> pass=1@4, aborted=0, busy high cycles 1–3; no ack through cycle 10 -> fail=1@11, fail_cnt=1.
- SYNC_ABORT=0: ch0 abort_rej=0, req@0, abort@2 -> pass=1 and aborted=1@3. ch1 abort_rej=1, same stimulus -> fail=1 and aborted=1@3.
- SYNC_ABORT=1: req@0, abort@2, ack@3 -> abort wins (applied at cycle 3 over ack), verdict@4. With SYNC_ABORT=0, abort@0 together with req@0 -> verdict@1.
- MIN_DLY=3: req@0, ack@1 -> ignored; ack@3 -> pass@4. Also ack@3 with new req@3 -> pass@4 and busy remains 1@4 (new attempt, cnt=1).
- dis=1 @2 during an attempt started @0 -> no pass/fail ever and busy=0@3. rst=1 mid-attempt -> all outputs 0 next cycle, no verdict.
- FCW=2, four channels fail together twice -> fail_cnt goes 0 -> 3 -> 3 (saturates, no wrap).
